// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake into the UART transmitter
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  ready;

    modport master (
        output P_DATA,
        output Data_Valid,
        input  ready
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        output ready
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, start/8 data LSB first/optional parity/stop
// Optional one-entry holding register for back-to-back frames: UART_TX_BUF_EN
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    uart_tx_if.slave                  s_if,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy
);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic                      bit_end;
    logic                      pending;
    logic                      load_frame;
    logic                      load_from_hold;
    logic [PRESCALE_WIDTH-1:0] presc_eff;

`ifdef UART_TX_BUF_EN
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

    assign s_if.ready     = !hold_valid_q;
    assign pending        = hold_valid_q || accept;
    assign load_from_hold = hold_valid_q;
`else
    assign s_if.ready     = (state_q == S_IDLE);
    assign pending        = 1'b0;
    assign load_from_hold = 1'b0;
`endif

    assign accept     = s_if.Data_Valid && s_if.ready;
    assign presc_eff  = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
    assign bit_end    = (cnt_q == presc_q - PRESCALE_WIDTH'(1));
    assign load_frame = ((state_q == S_IDLE) && accept) ||
                        ((state_q == S_STOP) && bit_end && pending);

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            presc_q   <= PRESCALE_WIDTH'(1);
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_BUF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // Bytes only park here when they cannot start a frame on the accepting edge.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (load_frame && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end
        if (accept && !load_frame) begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_if.P_DATA;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && (idx_q == IDX_W'(DATA_WIDTH - 1))) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: begin
                if (bit_end) state_d = pending ? S_START : S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Frame parameters are captured only on load_frame so mid-frame input changes are ignored.
    always_comb begin
        cnt_d     = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        idx_d     = idx_q;
        presc_d   = presc_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        if ((state_q == S_DATA) && bit_end) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (load_frame) begin
            cnt_d     = '0;
            idx_d     = '0;
            presc_d   = presc_eff;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
`ifdef UART_TX_BUF_EN
            data_d    = load_from_hold ? hold_data_q : s_if.P_DATA;
`else
            data_d    = s_if.P_DATA;
`endif
        end
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[idx_q];
            S_PARITY: tx_d = par_typ_q ? ~^data_q : ^data_q;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;
    logic       CLK;
    logic       RST;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int checks;
    int failures;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .s_if     (bus.slave),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .prescale (prescale),
        .TX_OUT   (TX_OUT),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
        @(negedge CLK);
        PAR_EN         = pe;
        PAR_TYP        = pt;
        prescale       = p;
        bus.P_DATA     = d;
        bus.Data_Valid = 1'b1;
        check("ready_before_accept", bus.ready, 1);
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        check("latency_tx", TX_OUT, 1);
        check("latency_busy", busy, 0);
    endtask

    task automatic expect_frame(input logic [10:0] bits, input int n, input int p,
                                input logic [7:0] exp_byte, input bit end_idle,
                                input int inj_c, input logic [7:0] inj_d, input logic inj_rdy);
        logic [7:0] rx;
        int c;
        rx = '0;
        c  = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                @(negedge CLK);
                check($sformatf("tx_bit%0d_cyc%0d", i, j), TX_OUT, bits[i]);
                check("busy_in_frame", busy, 1);
                if (j == p / 2 && i >= 1 && i <= 8) rx[i-1] = TX_OUT;
                if (c == inj_c) begin
                    check("inject_ready", bus.ready, inj_rdy);
                    bus.P_DATA     = inj_d;
                    bus.Data_Valid = 1'b1;
                end
                if (c == inj_c + 1) begin
                    bus.Data_Valid = 1'b0;
                    check("ready_after_inject", bus.ready, 0);
                end
                c++;
            end
        end
        check("rx_byte", rx, exp_byte);
        if (end_idle) begin
            @(negedge CLK);
            check("end_tx", TX_OUT, 1);
            check("end_busy", busy, 0);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        RST            = 1'b0;
        PAR_EN         = 1'b0;
        PAR_TYP        = 1'b0;
        prescale       = 6'd8;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;

        repeat (2) @(negedge CLK);
        check("reset_tx", TX_OUT, 1);
        check("reset_busy", busy, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("reset_ready", bus.ready, 1);

        // 0xAB, no parity, 8 cycles per bit
        send(8'hAB, 1'b0, 1'b0, 6'd8);
        expect_frame(11'b0_1_10101011_0, 10, 8, 8'hAB, 1'b1, -1, 8'h00, 1'b0);

        // even parity -> parity bit 1
        send(8'hAB, 1'b1, 1'b0, 6'd8);
        expect_frame(11'b1_1_10101011_0, 11, 8, 8'hAB, 1'b1, -1, 8'h00, 1'b0);

        // odd parity -> parity bit 0; settings change mid-frame must not matter
        send(8'hAB, 1'b1, 1'b1, 6'd8);
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        prescale = 6'd3;
        expect_frame(11'b1_0_10101011_0, 11, 8, 8'hAB, 1'b1, -1, 8'h00, 1'b0);

        // prescale 1 and 0 both give one cycle per bit
        send(8'h0F, 1'b0, 1'b0, 6'd1);
        expect_frame(11'b0_1_00001111_0, 10, 1, 8'h0F, 1'b1, -1, 8'h00, 1'b0);
        send(8'h0F, 1'b0, 1'b0, 6'd0);
        expect_frame(11'b0_1_00001111_0, 10, 1, 8'h0F, 1'b1, -1, 8'h00, 1'b0);

`ifdef UART_TX_BUF_EN
        // 0xC3 queued while 0x55 is on the line follows with no idle gap
        send(8'h55, 1'b0, 1'b0, 6'd8);
        expect_frame(11'b0_1_01010101_0, 10, 8, 8'h55, 1'b0, 20, 8'hC3, 1'b1);
        expect_frame(11'b0_1_11000011_0, 10, 8, 8'hC3, 1'b1, -1, 8'h00, 1'b0);
`else
        // byte offered while busy is dropped
        send(8'h55, 1'b0, 1'b0, 6'd8);
        expect_frame(11'b0_1_01010101_0, 10, 8, 8'h55, 1'b1, 20, 8'hC3, 1'b0);
        repeat (3) @(negedge CLK);
        check("dropped_busy", busy, 0);
        check("dropped_tx", TX_OUT, 1);
`endif

        // asynchronous reset during data bit 3 of 0xFF
        send(8'hFF, 1'b0, 1'b0, 6'd8);
        repeat (35) @(negedge CLK);
        check("pre_reset_busy", busy, 1);
        #2 RST = 1'b0;
        #1;
        check("async_reset_tx", TX_OUT, 1);
        check("async_reset_busy", busy, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("post_reset_ready", bus.ready, 1);
        send(8'h81, 1'b0, 1'b0, 6'd8);
        expect_frame(11'b0_1_10000001_0, 10, 8, 8'h81, 1'b1, -1, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
